serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder: one full-adder cell plus operand shift registers and a carry flip-flop. It adds two WIDTH-bit operands, one bit per clock, LSB first. It is the addition counterpart of the team's dataflow full subtractor and is the arithmetic core for the multi-cycle ALU labs. A start/busy/done handshake frames each operation.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- c_in  input  1  carry-in; captured on accepted start.
- sub  input  1  present only with SERIAL_ADDER_SUB_EN; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- c_out  output  1  carry out of the MSB.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on start:
  - Load a_sr=a, b_sr=b, carry=c_in, cnt=0, sum_sr=0.
- SHIFT, each cycle:
  - s = a_sr[0]^b_sr[0]^carry; co = majority(a_sr[0], b_sr[0], carry).
  - sum_sr = {s, sum_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; carry=co; cnt++.
  - When cnt==WIDTH-1, capture c_msb_in (the carry into the MSB, i.e. carry before the update) and go to DONE.
- DONE:
  - done=1 for exactly one cycle; sum=sum_sr, c_out=carry, overflow=c_msb_in^carry.
  - Next state is IDLE, or SHIFT if start=1 (back-to-back accept, reload as above).
- start is ignored while busy=1; there is no queueing.
- Operand inputs may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH; c_out is the 2^WIDTH bit.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, overflow=0; state=IDLE; all shift registers and cnt=0.
- Start accepted at edge 0 → busy=1 during cycles 1..WIDTH → done=1 in cycle WIDTH+1.
  - Latency is WIDTH+1 cycles from the accepting edge to done.
- busy=0 in the DONE cycle.
  - A start held high through DONE is accepted and busy returns next cycle. Throughput is one result per WIDTH+1 cycles.
- rst_n low at any time, including mid-SHIFT: immediate return to reset values. The partial result is discarded and no done is issued.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - When sub=1 at start, b is loaded inverted and the initial carry is forced to 1, so c_in is ignored. Result is a−b.
  - c_out=1 means no borrow; overflow follows the same rule.
  - sub=0 gives plain addition.
- Undefined: no sub port; add only.

## Structure
- Package serial_adder_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - CNT_W constant function ($clog2(WIDTH)).
- Sub-module full_adder_bit (a, b, ci → s, co), purely combinational.
  - Instantiated once; the serial datapath wraps registers around it.

## Test plan
- WIDTH=8, a=8'h3C, b=8'h05, c_in=0, start pulse → busy 8 cycles, done at cycle 9, sum=8'h41, c_out=0, overflow=0.
- a=8'hFF, b=8'h01, c_in=0 → sum=8'h00, c_out=1, overflow=0; a=8'h7F, b=8'h01 → sum=8'h80, c_out=0, overflow=1.
- a=8'h00, b=8'h00, c_in=1 → sum=8'h01, c_out=0; a start pulsed during busy is ignored, so exactly one done is seen.
- start held high continuously with a=8'h10, b=8'h20 → done pulses every 9 cycles, sum=8'h30 each time; busy reasserts the cycle after each done.
- rst_n asserted at SHIFT cycle 4 → all outputs 0 immediately, no done; the next operation completes normally.
- With SERIAL_ADDER_SUB_EN: sub=1, a=8'h05, b=8'h07 → sum=8'hFE, c_out=0 (borrow); a=8'h07, b=8'h05 → sum=8'h02, c_out=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Bit counter width; holds 0..WIDTH-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start,
        output a,
        output b,
        output c_in,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy,
        input  done,
        input  sum,
        input  c_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  c_in,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy,
        output done,
        output sum,
        output c_out,
        output overflow
    );

endinterface : serial_adder_if

// File: rtl/serial_adder_full_adder_bit.sv
// Single combinational full-adder cell; the serial datapath wraps
// registers around one instance of it.
module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// Bit-serial ripple adder, LSB first, one bit per clock, framed by start/busy/done.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b via inverted b, carry-in 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int CNT_W = cnt_w(WIDTH);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LAST_BIT = cnt_t'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q,  carry_d;
    cnt_t             cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             c_out_q,  c_out_d;
    logic             ovf_q,    ovf_d;

    logic fa_s;
    logic fa_co;
    logic load;
    logic last_bit;

    full_adder_bit u_fa (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // A start is accepted in IDLE and also in DONE, giving back-to-back operation.
    assign load     = bus.start && (state_q != SHIFT);
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    state_d = bus.start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state only; no input-to-output path.
    always_comb begin
        bus.busy     = (state_q == SHIFT);
        bus.done     = (state_q == DONE);
        bus.sum      = sum_q;
        bus.c_out    = c_out_q;
        bus.overflow = ovf_q;
    end

    // Serial datapath next-state.
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;

        if (load) begin
            a_sr_d   = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
            b_sr_d   = bus.sub ? ~bus.b : bus.b;
            carry_d  = bus.sub | bus.c_in;
`else
            b_sr_d   = bus.b;
            carry_d  = bus.c_in;
`endif
            cnt_d    = '0;
            sum_sr_d = '0;
        end else if (state_q == SHIFT) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
            carry_d  = fa_co;
            cnt_d    = cnt_q + cnt_t'(1);
            // On the MSB, carry_q is the carry into the MSB and fa_co the carry out.
            if (last_bit) begin
                sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
                c_out_d = fa_co;
                ovf_d   = carry_q ^ fa_co;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is reset, including the shift registers, so a
        // mid-operation reset leaves no stale partial result behind.
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_done;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sb);
        bus.start = st;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = sb;
`else
        if (sb) bus.c_in = cin;
`endif
    endtask

    // One full operation: accept, W busy cycles, done, then done drops and sum holds.
    // poke_mid pulses start again during busy, which must be ignored.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sb, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf, input bit poke_mid);
        drive(1'b1, a, b, cin, sb);
        tick();
        drive(1'b0, W'($urandom), W'($urandom), 1'b0, 1'b0);
        n_done = 0;
        for (int i = 1; i <= W; i++) begin
            if (i == 1) check({tag, ".busy_first"}, 32'(bus.busy), 32'd1);
            if (i == 3 && poke_mid) drive(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
            if (i == 4) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            if (!bus.busy) n_done += 100;
            if (bus.done) n_done++;
            tick();
        end
        check({tag, ".busy_during"}, 32'(n_done), 32'd0);
        check({tag, ".done"},     32'(bus.done),     32'd1);
        check({tag, ".busy_off"}, 32'(bus.busy),     32'd0);
        check({tag, ".sum"},      32'(bus.sum),      32'(exp_sum));
        check({tag, ".c_out"},    32'(bus.c_out),    32'(exp_cout));
        check({tag, ".ovf"},      32'(bus.overflow), 32'(exp_ovf));
        tick();
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".sum_hold"},   32'(bus.sum),  32'(exp_sum));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        check("reset.busy", 32'(bus.busy),     32'd0);
        check("reset.done", 32'(bus.done),     32'd0);
        check("reset.sum",  32'(bus.sum),      32'd0);
        check("reset.cout", 32'(bus.c_out),    32'd0);
        check("reset.ovf",  32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic add, carry chain, signed overflow cases.
        run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Carry-in only, with a start pulse during busy that must be ignored.
        run_op("cin_only", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) n_done++;
            tick();
        end
        check("cin_only.no_extra", 32'(n_done), 32'd0);

        // Start held high: a result every W+1 cycles, busy back right after done.
        drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        tick();
        for (int r = 0; r < 3; r++) begin
            n_done = 0;
            for (int i = 1; i <= W; i++) begin
                if (!bus.busy || bus.done) n_done++;
                tick();
            end
            check($sformatf("b2b%0d.busy", r), 32'(n_done),   32'd0);
            check($sformatf("b2b%0d.done", r), 32'(bus.done), 32'd1);
            check($sformatf("b2b%0d.sum",  r), 32'(bus.sum),  32'h30);
            if (r == 2) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            tick();
        end
        check("b2b.idle_after", 32'(bus.busy), 32'd0);

        // Reset during SHIFT cycle 4: immediate clear, no done afterwards.
        drive(1'b1, 8'hC3, 8'h5A, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        check("rst_mid.busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.busy", 32'(bus.busy),     32'd0);
        check("rst_mid.done", 32'(bus.done),     32'd0);
        check("rst_mid.sum",  32'(bus.sum),      32'd0);
        check("rst_mid.cout", 32'(bus.c_out),    32'd0);
        check("rst_mid.ovf",  32'(bus.overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) n_done++;
            tick();
        end
        check("rst_mid.no_done", 32'(n_done), 32'd0);
        run_op("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
